// File: rtl/snn_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snn_cmd_pkg: command codes shared by the SNN bus agents and the      |
// | encoder state type.                                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package snn_cmd_pkg;

    function automatic int cmd_load_value(input int cmd_width);
        return (cmd_width > 0) ? 1 : 0;
    endfunction

    function automatic int cmd_clear(input int cmd_width);
        return (1 << cmd_width) - 3;
    endfunction

    function automatic int cmd_set_input_train_length(input int cmd_width);
        return (1 << cmd_width) - 4;
    endfunction

    function automatic int cmd_set_input_train_frequency(input int cmd_width);
        return (1 << cmd_width) - 5;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

endpackage
`default_nettype wire

// File: rtl/spike_rate_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spike_rate_accumulator: phase accumulator whose carry-out is the     |
// | rate-coded spike for the current slot.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spike_rate_accumulator #(
    parameter int INT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 step,
    input  logic [INT_WIDTH-1:0] value,
    output logic                 spike
);

    logic [INT_WIDTH-1:0] acc_q;
    logic [INT_WIDTH-1:0] acc_d;
    logic [INT_WIDTH:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, value};
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (step) begin
            acc_d = sum[INT_WIDTH-1:0];
        end
    end

    // Spike is valid only in the cycle the owner asserts step.
    assign spike = sum[INT_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spike_train_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spike_train_encoder: turns a latched integer into a rate-coded spike |
// | train advanced by bus run ticks (cmd == 0).                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spike_train_encoder
    import snn_cmd_pkg::*;
#(
    parameter int ENCODER_ID           = -1,
    parameter int ADDR_WIDTH           = 8,
    parameter int CMD_WIDTH            = 8,
    parameter int INT_WIDTH            = 8,
    parameter int DEFAULT_TRAIN_LENGTH = 16,
    parameter int DEFAULT_TRAIN_PERIOD = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [CMD_WIDTH-1:0]   cmd,
    input  logic [2*INT_WIDTH-1:0] cmd_arg,
    output logic                   out,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ADDR_WIDTH-1:0] C_MY_ADDR  = ADDR_WIDTH'(ENCODER_ID);
    localparam logic [CMD_WIDTH-1:0]  C_CMD_RUN  = '0;
    localparam logic [CMD_WIDTH-1:0]  C_CMD_LOAD = CMD_WIDTH'(cmd_load_value(CMD_WIDTH));
    localparam logic [CMD_WIDTH-1:0]  C_CMD_CLR  = CMD_WIDTH'(cmd_clear(CMD_WIDTH));
    localparam logic [CMD_WIDTH-1:0]  C_CMD_LEN  = CMD_WIDTH'(cmd_set_input_train_length(CMD_WIDTH));
    localparam logic [CMD_WIDTH-1:0]  C_CMD_FRQ  = CMD_WIDTH'(cmd_set_input_train_frequency(CMD_WIDTH));
    localparam logic [INT_WIDTH-1:0]  C_ONE      = INT_WIDTH'(1);
    localparam logic [INT_WIDTH-1:0]  C_DEF_LEN  = INT_WIDTH'(DEFAULT_TRAIN_LENGTH);
    localparam logic [INT_WIDTH-1:0]  C_DEF_PER  = INT_WIDTH'(DEFAULT_TRAIN_PERIOD);

    enc_state_e           state_q, state_d;
    logic [INT_WIDTH-1:0] value_q, value_d;
    logic [INT_WIDTH-1:0] length_q, length_d;
    logic [INT_WIDTH-1:0] period_q, period_d;
    logic [INT_WIDTH-1:0] shadow_length_q, shadow_length_d;
    logic [INT_WIDTH-1:0] shadow_period_q, shadow_period_d;
    logic [INT_WIDTH-1:0] tick_q, tick_d;
    logic [INT_WIDTH-1:0] slot_q, slot_d;
    logic                 out_q, out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 acc_clear, acc_step, acc_spike;
    logic [INT_WIDTH-1:0] arg;
    logic                 unused_arg_hi;

    assign arg           = cmd_arg[INT_WIDTH-1:0];
    assign unused_arg_hi = ^cmd_arg[2*INT_WIDTH-1:INT_WIDTH];

    spike_rate_accumulator #(
        .INT_WIDTH (INT_WIDTH)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .step  (acc_step),
        .value (value_q),
        .spike (acc_spike)
    );

    always_comb begin
        state_d         = state_q;
        value_d         = value_q;
        length_d        = length_q;
        period_d        = period_q;
        shadow_length_d = shadow_length_q;
        shadow_period_d = shadow_period_q;
        tick_d          = tick_q;
        slot_d          = slot_q;
        out_d           = 1'b0;
        busy_d          = busy_q;
        done_d          = 1'b0;
        acc_clear       = 1'b0;
        acc_step        = 1'b0;

        // DONE always lasts one clock; LOAD or CLEAR below may override it.
        if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
        end

        if (cmd == C_CMD_CLR) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            tick_d    = '0;
            slot_d    = '0;
            acc_clear = 1'b1;
        end else if (cmd == C_CMD_RUN) begin
            if (state_q == ST_RUN) begin
                if (slot_q == period_q - C_ONE) begin
                    slot_d   = '0;
                    acc_step = 1'b1;
                    out_d    = acc_spike;
                end else begin
                    slot_d = slot_q + C_ONE;
                end
                tick_d = tick_q + C_ONE;
                if (tick_q == length_q - C_ONE) begin
                    state_d = ST_DONE;
                end
            end
        end else if (addr == C_MY_ADDR) begin
            if (cmd == C_CMD_LOAD) begin
                value_d   = arg;
                length_d  = shadow_length_q;
                period_d  = shadow_period_q;
                tick_d    = '0;
                slot_d    = '0;
                acc_clear = 1'b1;
                done_d    = 1'b0;
                if (shadow_length_q == '0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end else if (cmd == C_CMD_LEN) begin
                shadow_length_d = arg;
            end else if (cmd == C_CMD_FRQ) begin
                shadow_period_d = (arg == '0) ? C_ONE : arg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            value_q         <= '0;
            length_q        <= '0;
            period_q        <= C_ONE;
            shadow_length_q <= C_DEF_LEN;
            shadow_period_q <= C_DEF_PER;
            tick_q          <= '0;
            slot_q          <= '0;
            out_q           <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            value_q         <= value_d;
            length_q        <= length_d;
            period_q        <= period_d;
            shadow_length_q <= shadow_length_d;
            shadow_period_q <= shadow_period_d;
            tick_q          <= tick_d;
            slot_q          <= slot_d;
            out_q           <= out_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_train_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spike_train_encoder: directed scenarios for spike_train_encoder.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_spike_train_encoder;

    localparam logic [7:0] C_ID   = 8'hFF;
    localparam logic [7:0] C_LOAD = 8'd1;
    localparam logic [7:0] C_LEN  = 8'd252;
    localparam logic [7:0] C_FRQ  = 8'd251;
    localparam logic [7:0] C_CLR  = 8'd253;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [7:0]  cmd = 8'h00;
    logic [15:0] cmd_arg = 16'h0000;
    logic        out, busy, done;

    int checks = 0;
    int errors = 0;

    spike_train_encoder dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .cmd     (cmd),
        .cmd_arg (cmd_arg),
        .out     (out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic [7:0] a, input logic [7:0] c, input logic [15:0] arg);
        addr    = a;
        cmd     = c;
        cmd_arg = arg;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        cycle(8'h00, 8'h00, 16'h0000);
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++; if (out !== 1'b0)  begin errors++; $display("FAIL reset_out got %b want 0", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        rst = 1'b1;
        tick();
    endtask

    // value 128, default length 16 and period 1: spike on every even tick.
    task automatic test_default_train();
        logic exp;
        cycle(C_ID, C_LOAD, 16'd128);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dflt_busy_after_load got %b want 1", busy); end
        for (int t = 1; t <= 16; t++) begin
            tick();
            exp = (t % 2 == 0);
            checks++; if (out !== exp) begin errors++; $display("FAIL dflt_out_t%0d got %b want %b", t, out, exp); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL dflt_done_t%0d got %b want 0", t, done); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL dflt_done_pulse got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dflt_busy_end got %b want 0", busy); end
        checks++; if (out !== 1'b0)  begin errors++; $display("FAIL dflt_out_end got %b want 0", out); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL dflt_done_one_clock got %b want 0", done); end
    endtask

    // Length 8, period 2, value 255: slots at 2,4,6,8; first slot has no carry.
    task automatic test_period();
        logic exp;
        cycle(C_ID, C_LEN, 16'd8);
        cycle(C_ID, C_FRQ, 16'd2);
        cycle(C_ID, C_LOAD, 16'd255);
        for (int t = 1; t <= 8; t++) begin
            tick();
            exp = (t == 4) || (t == 6) || (t == 8);
            checks++; if (out !== exp)   begin errors++; $display("FAIL per_out_t%0d got %b want %b", t, out, exp); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL per_busy_t%0d got %b want 1", t, busy); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL per_done got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL per_busy_end got %b want 0", busy); end
    endtask

    // Period write of 0 must act as 1; a foreign command is not a tick.
    task automatic test_foreign_cmd();
        logic exp;
        cycle(C_ID, C_FRQ, 16'd0);
        cycle(C_ID, C_LOAD, 16'd64);
        for (int t = 1; t <= 8; t++) begin
            if (t == 4) begin
                cycle(8'h12, 8'h07, 16'h00AA);
                checks++; if (out !== 1'b0)  begin errors++; $display("FAIL fgn_out got %b want 0", out); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fgn_busy got %b want 1", busy); end
            end
            tick();
            exp = (t == 4) || (t == 8);
            checks++; if (out !== exp)    begin errors++; $display("FAIL fgn_out_t%0d got %b want %b", t, out, exp); end
            checks++; if (done !== 1'b0)  begin errors++; $display("FAIL fgn_done_t%0d got %b want 0", t, done); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL fgn_done got %b want 1", done); end
    endtask

    // value 96: acc 96,192,32(spike),128 after tick 4; CLEAR then LOAD 64 starts from 0.
    task automatic test_clear();
        logic exp;
        cycle(C_ID, C_LOAD, 16'd96);
        for (int t = 1; t <= 4; t++) tick();
        cycle(8'h00, C_CLR, 16'h0000);
        checks++; if (out !== 1'b0)  begin errors++; $display("FAIL clr_out got %b want 0", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", busy); end
        for (int t = 1; t <= 6; t++) begin
            tick();
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL clr_idle_t%0d got done=%b busy=%b want 0 0", t, done, busy);
            end
        end
        cycle(C_ID, C_LOAD, 16'd64);
        for (int t = 1; t <= 8; t++) begin
            tick();
            exp = (t == 4) || (t == 8);
            checks++; if (out !== exp) begin errors++; $display("FAIL clr_reload_t%0d got %b want %b", t, out, exp); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clr_reload_done got %b want 1", done); end
    endtask

    task automatic test_shadow_midtrain();
        logic exp;
        cycle(C_ID, C_LOAD, 16'd128);
        for (int t = 1; t <= 8; t++) begin
            if (t == 4) cycle(C_ID, C_LEN, 16'd4);
            tick();
            exp = (t % 2 == 0);
            checks++; if (out !== exp)   begin errors++; $display("FAIL shd_out_t%0d got %b want %b", t, out, exp); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL shd_busy_t%0d got %b want 1", t, busy); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL shd_done_old got %b want 1", done); end
        cycle(C_ID, C_LOAD, 16'd128);
        for (int t = 1; t <= 4; t++) begin
            tick();
            exp = (t % 2 == 0);
            checks++; if (out !== exp) begin errors++; $display("FAIL shd_new_out_t%0d got %b want %b", t, out, exp); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL shd_done_new got %b want 1", done); end
    endtask

    task automatic test_zero_length();
        cycle(C_ID, C_LEN, 16'd0);
        cycle(C_ID, C_LOAD, 16'd200);
        checks++; if (busy !== 1'b0 || out !== 1'b0) begin
            errors++; $display("FAIL zlen_load got busy=%b out=%b want 0 0", busy, out);
        end
        tick();
        checks++; if (done !== 1'b1 || out !== 1'b0) begin
            errors++; $display("FAIL zlen_done got done=%b out=%b want 1 0", done, out);
        end
    endtask

    task automatic test_async_reset();
        cycle(C_ID, C_LEN, 16'd4);
        cycle(C_ID, C_LOAD, 16'd128);
        tick();
        tick();
        checks++; if (out !== 1'b1) begin errors++; $display("FAIL ars_pre_out got %b want 1", out); end
        #2 rst = 1'b0;
        #1;
        checks++; if (out !== 1'b0)  begin errors++; $display("FAIL ars_out got %b want 0", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ars_busy got %b want 0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ars_done got %b want 0", done); end
        cycle(C_ID, C_LOAD, 16'd128);
        for (int t = 1; t <= 16; t++) begin
            tick();
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ars_len_busy_t%0d got %b want 1", t, busy); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ars_len_done got %b want 1", done); end
    endtask

    initial begin
        test_reset();
        test_default_train();
        test_period();
        test_foreign_cmd();
        test_clear();
        test_shadow_midtrain();
        test_zero_length();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spike_train_encoder.md
Name: spike_train_encoder

Overview:
- Upstream stage of spiking_neuron_2in: converts an integer input value into a rate-coded spike train on a 1-bit wire that drives a neuron in1/in2.
- Sits on the shared addr/cmd/cmd_arg command bus.
- Is configured by the train-length and train-frequency commands.
- Advances only on run ticks (cmd == 0), the same ticks on which neurons advance.

Parameters:
- ENCODER_ID, -1, bus address of this encoder.
- ADDR_WIDTH, 8, address bus width.
- CMD_WIDTH, 8, command bus width.
- INT_WIDTH, 8, input value width; cmd_arg is 2*INT_WIDTH.
- DEFAULT_TRAIN_LENGTH, 16, train length in ticks after reset.
- DEFAULT_TRAIN_PERIOD, 1, ticks per spike slot after reset.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  reset: asynchronous, active-low.
- addr  input  ADDR_WIDTH  target address of the command.
- cmd  input  CMD_WIDTH  command code; 0 = run tick.
- cmd_arg  input  2*INT_WIDTH  command argument.
- out  output  1  spike output, registered.
- busy  output  1  high while a train is running.
- done  output  1  one-clock pulse after the last tick of a train.

Behaviour:
- Commands are decoded only when addr == ENCODER_ID, except CMD_CLEAR, which is broadcast:
  - CMD_LOAD_VALUE = 1: latch value = cmd_arg[INT_WIDTH-1:0]. Copy the shadow length and period into active registers. Clear accumulator, tick counter and slot counter. Enter RUN.
  - CMD_SET_INPUT_TRAIN_LENGTH = 2^CMD_WIDTH-4: shadow_length <= cmd_arg[INT_WIDTH-1:0].
  - CMD_SET_INPUT_TRAIN_FREQUENCY = 2^CMD_WIDTH-5: shadow_period <= cmd_arg[INT_WIDTH-1:0]; period 0 is stored as 1.
  - CMD_CLEAR = 2^CMD_WIDTH-3: abort. Go to IDLE; out=0, busy=0, done=0, accumulator=0. Shadow config is kept.
  - Any other non-zero cmd: no effect; out=0 and state frozen.
- Shadow writes are accepted in any state. They affect only the next LOAD, never a running train.
- Reset (async, rst low): state IDLE, out=0, busy=0, done=0, value=0, accumulator=0, both counters 0, shadow_length=DEFAULT_TRAIN_LENGTH, shadow_period=DEFAULT_TRAIN_PERIOD. Reset mid-train aborts it with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: out=0, busy=0. LOAD -> RUN. If the active length is 0, LOAD goes straight to DONE with no spikes.
  - RUN: busy=1. On each cmd==0 edge:
    - slot_cnt increments.
    - When slot_cnt reaches period-1 (a slot), slot_cnt wraps to 0 and acc_next = {1'b0, acc[INT_WIDTH-1:0]} + value.
    - out <= carry bit acc_next[INT_WIDTH]; acc <= acc_next[INT_WIDTH-1:0].
    - On non-slot ticks, out <= 0.
    - tick_cnt increments. The tick where tick_cnt reaches length-1 is the final tick; on it the FSM goes to DONE.
  - DONE: exactly one clock with done=1, busy=0; out returns to 0 that clock. Then -> IDLE.
- Cycle rules:
  - Latency is one edge: a spike computed on a run-tick edge is visible for exactly one clock after that edge.
  - Cycles with cmd != 0 do not count as ticks and force out=0.
  - LOAD during RUN or DONE restarts cleanly: new value, accumulator 0, no done pulse for the aborted train.
  - value=0 gives no spikes.
  - value=2^INT_WIDTH-1 gives spikes on all slots except the first.
  - Expected spike count for a train = floor(value*slots/2^INT_WIDTH).
- Arithmetic: all counters and the accumulator are unsigned; the accumulator is INT_WIDTH+1 bits wide, and the carry is the spike.

Decomposition:
- Package snn_cmd_pkg holds:
  - CMD_LOAD_VALUE, CMD_CLEAR, CMD_SET_INPUT_TRAIN_LENGTH, CMD_SET_INPUT_TRAIN_FREQUENCY as functions of CMD_WIDTH, shared with spiking_neuron_2in.
  - The encoder state enum typedef.
- One sub-module, spike_rate_accumulator:
  - Inputs: clk, rst, clear, step, value.
  - Output: spike.
  - Contains the accumulator and carry logic.
- The FSM, counters and command decode stay in the top module.

Test Plan:
- Reset -> out=0, busy=0, done=0. Then LOAD value=128 with default length 16 and period 1, followed by 16 run ticks -> spikes on ticks 2,4,...,16 (8 spikes); done pulses one clock after tick 16.
- SET_LENGTH 8, SET_FREQUENCY 2, LOAD value=255, then 8 run ticks -> slots on ticks 2,4,6,8; spikes on ticks 4,6,8 (3 spikes); busy high for exactly 8 ticks.
- LOAD value=64 with length 8, and a non-zero foreign cmd inserted between ticks 3 and 4 -> the foreign cycle does not count as a tick; the train ends after the 8th cmd==0 cycle, with spikes on ticks 4 and 8 only.
- Mid-train CMD_CLEAR at tick 5 -> out=0 and busy=0 next clock; no done pulse. A later LOAD restarts with accumulator 0.
- Mid-train SET_LENGTH 4 followed by continued ticks -> the running train keeps its old length. The next LOAD uses 4, and done follows its 4th tick.
- rst asserted low asynchronously mid-train (between clock edges) -> out/busy drop immediately. After release, the shadow length equals DEFAULT_TRAIN_LENGTH again.
